// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store, memory, stall and error signals around the
// single-port memory arbiter. The arbiter uses slave and its environment uses master.
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 10
);
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_flush_i;
   logic [31:0]   if_rdata_o;
   logic          if_valid_o;

   logic          d_req_i;
   logic          d_we_i;
   logic [AW-1:0] d_addr_i;
   logic [31:0]   d_wdata_i;
   logic [31:0]   d_rdata_o;
   logic          d_valid_o;

   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i;
   logic          mem_ack_i;

   logic          stall_if_o;
   logic          stall_d_o;
   logic          err_o;
   logic          err_clr_i;

   modport slave (
      input  if_req_i, if_addr_i, if_flush_i,
      output if_rdata_o, if_valid_o,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
      output d_rdata_o, d_valid_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i,
      output stall_if_o, stall_d_o, err_o,
      input  err_clr_i
   );

   modport master (
      output if_req_i, if_addr_i, if_flush_i,
      input  if_rdata_o, if_valid_o,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i,
      input  d_rdata_o, d_valid_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i,
      input  stall_if_o, stall_d_o, err_o,
      output err_clr_i
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one memory port. Data has
// priority with a bounded run length, and a watchdog turns a missing ack into an error.
module mem_port_arbiter #(
   parameter int unsigned AW      = 10,
   parameter int unsigned MAX_RUN = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input logic                clk,
   input logic                rst_n,
   mem_port_arbiter_if.slave  bus
);
   localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);
   localparam int unsigned TMR_W = 5;
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

   state_e             state_q, state_d;
   logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               flushed_q, flushed_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic [AW-1:0]      mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic [31:0]        if_rdata_q, if_rdata_d;
   logic               if_valid_q, if_valid_d;
   logic [31:0]        d_rdata_q, d_rdata_d;
   logic               d_valid_q, d_valid_d;
   logic               err_q, err_d;
   logic               if_ok, tmo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         run_cnt_q   <= '0;
         timer_q     <= '0;
         flushed_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         d_rdata_q   <= '0;
         d_valid_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_cnt_q   <= run_cnt_d;
         timer_q     <= timer_d;
         flushed_q   <= flushed_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         if_valid_q  <= if_valid_d;
         d_rdata_q   <= d_rdata_d;
         d_valid_q   <= d_valid_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      run_cnt_d   = run_cnt_q;
      timer_d     = timer_q;
      flushed_d   = flushed_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      if_valid_d  = 1'b0;
      d_rdata_d   = d_rdata_q;
      d_valid_d   = 1'b0;
      err_d       = err_q;
      tmo         = 1'b0;
      if_ok       = bus.if_req_i & ~bus.if_flush_i;

      case (state_q)
         IDLE: begin
            // Data wins unless fetch has already waited out MAX_RUN data grants.
            if (bus.d_req_i && !(if_ok && run_cnt_q == RUN_MAX)) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we_i;
               mem_addr_d  = bus.d_addr_i;
               mem_wdata_d = bus.d_wdata_i;
               timer_d     = '0;
               if (!bus.if_req_i)            run_cnt_d = '0;
               else if (run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + RUN_W'(1);
            end else if (if_ok) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr_i;
               mem_wdata_d = '0;
               timer_d     = '0;
               run_cnt_d   = '0;
               flushed_d   = 1'b0;
            end
         end
         BUSY_IF, BUSY_D: begin
            tmo = ~bus.mem_ack_i & (timer_q == TMO_LAST);
            if (state_q == BUSY_IF && bus.if_flush_i) flushed_d = 1'b1;
            if (bus.mem_ack_i || tmo) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == BUSY_IF) begin
                  // A flushed fetch finishes at memory but is never delivered.
                  if (!flushed_q && !bus.if_flush_i) begin
                     if_valid_d = 1'b1;
                     if_rdata_d = tmo ? '0 : bus.mem_rdata_i;
                  end
               end else begin
                  d_valid_d = 1'b1;
                  if (tmo)            d_rdata_d = '0;
                  else if (!mem_we_q) d_rdata_d = bus.mem_rdata_i;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (tmo)                err_d = 1'b1;
      else if (bus.err_clr_i) err_d = 1'b0;
   end

   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.if_valid_o  = if_valid_q;
   assign bus.d_rdata_o   = d_rdata_q;
   assign bus.d_valid_o   = d_valid_q;
   assign bus.err_o       = err_q;
   assign bus.stall_if_o  = bus.if_req_i & ~if_valid_q;
   assign bus.stall_d_o   = bus.d_req_i & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, starvation, flush,
// timeout and mid-access reset, each step with hand-computed expectations.
module tb_mem_port_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   mem_port_arbiter_if #(.AW(10)) bus ();

   mem_port_arbiter #(.AW(10), .MAX_RUN(4), .TIMEOUT(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a memory request, acks it in its first cycle, returns in the valid cycle.
   task automatic serve(input logic [31:0] rd, output logic we, output logic [9:0] addr,
                        output logic ok);
      ok = 1'b0; we = 1'b0; addr = '0;
      for (int i = 0; i < 20; i++) begin
         if (bus.mem_req_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) begin
         we   = bus.mem_we_o;
         addr = bus.mem_addr_o;
         bus.mem_ack_i   = 1'b1;
         bus.mem_rdata_i = rd;
         tick();
         bus.mem_ack_i = 1'b0;
      end
   endtask

   logic       s_we, s_ok;
   logic [9:0] s_addr;
   int         stores, fetch_idx, cnt;

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0;
      bus.if_req_i = 0; bus.if_addr_i = '0; bus.if_flush_i = 0;
      bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
      bus.mem_rdata_i = '0; bus.mem_ack_i = 0; bus.err_clr_i = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_req", bus.mem_req_o, 1'b0);
      chk("rst_mem_addr", bus.mem_addr_o, 10'h000);
      chk("rst_if_valid", bus.if_valid_o, 1'b0);
      chk("rst_d_valid", bus.d_valid_o, 1'b0);
      chk("rst_err", bus.err_o, 1'b0);
      chk("rst_rdata", bus.if_rdata_o | bus.d_rdata_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Fetch alone: ack two cycles after mem_req_o rises
      bus.if_req_i = 1; bus.if_addr_i = 10'h010; #1;
      chk("f_stall_c0", bus.stall_if_o, 1'b1);
      tick();
      chk("f_req_c1", bus.mem_req_o, 1'b1);
      chk("f_addr_c1", bus.mem_addr_o, 10'h010);
      chk("f_we_c1", bus.mem_we_o, 1'b0);
      tick();
      chk("f_req_c2", bus.mem_req_o, 1'b1);
      tick();
      bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h1234_5678; #1;
      chk("f_stall_c3", bus.stall_if_o, 1'b1);
      chk("f_valid_c3", bus.if_valid_o, 1'b0);
      tick();
      bus.mem_ack_i = 0;
      chk("f_valid_c4", bus.if_valid_o, 1'b1);
      chk("f_rdata_c4", bus.if_rdata_o, 32'h1234_5678);
      chk("f_req_c4", bus.mem_req_o, 1'b0);
      chk("f_stall_c4", bus.stall_if_o, 1'b0);
      bus.if_req_i = 0;
      tick();
      chk("f_valid_c5", bus.if_valid_o, 1'b0);

      // Simultaneous requests: data first, fetch right after d_valid
      bus.if_req_i = 1; bus.if_addr_i = 10'h010;
      bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 10'h200; #1;
      chk("s_stall_d_c0", bus.stall_d_o, 1'b1);
      tick();
      chk("s_addr_c1", bus.mem_addr_o, 10'h200);
      chk("s_we_c1", bus.mem_we_o, 1'b0);
      chk("s_stall_if_c1", bus.stall_if_o, 1'b1);
      bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hA5A5_0200;
      tick();
      bus.mem_ack_i = 0;
      chk("s_d_valid", bus.d_valid_o, 1'b1);
      chk("s_d_rdata", bus.d_rdata_o, 32'hA5A5_0200);
      chk("s_if_valid_early", bus.if_valid_o, 1'b0);
      chk("s_stall_if_c2", bus.stall_if_o, 1'b1);
      bus.d_req_i = 0;
      tick();
      chk("s_f_req", bus.mem_req_o, 1'b1);
      chk("s_f_addr", bus.mem_addr_o, 10'h010);
      bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hCAFE_0034;
      tick();
      bus.mem_ack_i = 0;
      chk("s_if_valid", bus.if_valid_o, 1'b1);
      chk("s_if_rdata", bus.if_rdata_o, 32'hCAFE_0034);
      bus.if_req_i = 0;
      tick();

      // Flush during BUSY_IF
      bus.if_req_i = 1; bus.if_addr_i = 10'h020;
      tick();
      chk("fl_req", bus.mem_req_o, 1'b1);
      bus.if_flush_i = 1; bus.if_req_i = 0;
      tick();
      bus.if_flush_i = 0;
      chk("fl_req_held", bus.mem_req_o, 1'b1);
      bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hDEAD_BEEF;
      tick();
      bus.mem_ack_i = 0;
      chk("fl_req_done", bus.mem_req_o, 1'b0);
      chk("fl_no_valid", bus.if_valid_o, 1'b0);
      chk("fl_rdata_kept", bus.if_rdata_o, 32'hCAFE_0034);
      tick();
      chk("fl_no_valid2", bus.if_valid_o, 1'b0);

      // Flush in IDLE blocks that cycle's fetch grant
      bus.if_req_i = 1; bus.if_addr_i = 10'h030; bus.if_flush_i = 1;
      tick();
      chk("ifl_no_grant", bus.mem_req_o, 1'b0);
      bus.if_flush_i = 0;
      tick();
      chk("ifl_grant", bus.mem_req_o, 1'b1);
      chk("ifl_addr", bus.mem_addr_o, 10'h030);
      bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h0000_0030;
      tick();
      bus.mem_ack_i = 0;
      chk("ifl_valid", bus.if_valid_o, 1'b1);
      chk("ifl_rdata", bus.if_rdata_o, 32'h0000_0030);
      bus.if_req_i = 0;
      tick();

      // Starvation: 6 held stores against a held fetch
      stores = 0; fetch_idx = -1;
      bus.if_req_i = 1; bus.if_addr_i = 10'h040;
      bus.d_req_i = 1; bus.d_we_i = 1; bus.d_addr_i = 10'h100; bus.d_wdata_i = 32'h5000_0000;
      for (int g = 0; g < 7; g++) begin
         serve(32'h0000_0040, s_we, s_addr, s_ok);
         chk("st_serve_ok", s_ok, 1'b1);
         if (!s_ok) break;
         if (s_we) begin
            stores++;
            chk("st_d_valid", bus.d_valid_o, 1'b1);
            chk("st_addr", s_addr, 32'(10'h100 + 10'(stores - 1)));
            if (stores == 6) bus.d_req_i = 0;
            else begin
               bus.d_addr_i  = 10'(10'h100 + 10'(stores));
               bus.d_wdata_i = 32'h5000_0000 + 32'(stores);
            end
         end else begin
            fetch_idx = g;
            chk("st_f_addr", s_addr, 10'h040);
            chk("st_if_valid", bus.if_valid_o, 1'b1);
            bus.if_req_i = 0;
         end
      end
      chk("st_fetch_idx", fetch_idx, 4);
      chk("st_stores", stores, 6);
      chk("st_d_rdata_kept", bus.d_rdata_o, 32'hA5A5_0200);
      tick();

      // Timeout on a load with no ack
      bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 10'h300;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.mem_req_o) cnt++;
         else break;
      end
      chk("to_req_cycles", cnt, 15);
      chk("to_d_valid", bus.d_valid_o, 1'b1);
      chk("to_d_rdata", bus.d_rdata_o, 32'h0);
      chk("to_err", bus.err_o, 1'b1);
      bus.d_req_i = 0;
      tick();
      chk("to_err_sticky", bus.err_o, 1'b1);
      chk("to_valid_once", bus.d_valid_o, 1'b0);
      bus.err_clr_i = 1;
      tick();
      bus.err_clr_i = 0;
      chk("to_err_clr", bus.err_o, 1'b0);

      // Ack in IDLE is ignored
      bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hFFFF_FFFF;
      tick();
      bus.mem_ack_i = 0;
      chk("ia_if_valid", bus.if_valid_o, 1'b0);
      chk("ia_d_valid", bus.d_valid_o, 1'b0);
      chk("ia_mem_req", bus.mem_req_o, 1'b0);

      // Reset in the middle of a store
      bus.d_req_i = 1; bus.d_we_i = 1; bus.d_addr_i = 10'h180; bus.d_wdata_i = 32'h77;
      tick();
      chk("mr_req", bus.mem_req_o, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_req_async", bus.mem_req_o, 1'b0);
      chk("mr_addr_async", bus.mem_addr_o, 10'h000);
      chk("mr_we_async", bus.mem_we_o, 1'b0);
      bus.d_req_i = 0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("mr_no_valid1", bus.d_valid_o, 1'b0);
      chk("mr_idle_req", bus.mem_req_o, 1'b0);
      tick();
      chk("mr_no_valid2", bus.d_valid_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, meaning memory word-address width.
REQ-002 SHALL have parameter MAX_RUN, default 4, meaning the maximum number of consecutive data grants while fetch waits.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum cycles mem_req_o stays high without mem_ack_i.
REQ-004 SHALL have port clk, input, 1, meaning system clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports if_req_i, input, 1, and if_addr_i, input, AW, meaning the fetch request and its address.
REQ-007 SHALL have port if_flush_i, input, 1, meaning discard the in-flight or pending fetch.
REQ-008 SHALL have ports if_rdata_o, output, 32, and if_valid_o, output, 1, meaning the fetched instruction and its 1-cycle valid pulse.
REQ-009 SHALL have ports d_req_i, input, 1; d_we_i, input, 1; d_addr_i, input, AW; and d_wdata_i, input, 32, meaning the load/store request, its write enable, address and write data.
REQ-010 SHALL have ports d_rdata_o, output, 32, and d_valid_o, output, 1, meaning load data and the 1-cycle completion pulse.
REQ-011 SHALL have ports mem_req_o, output, 1; mem_we_o, output, 1; mem_addr_o, output, AW; and mem_wdata_o, output, 32, meaning the single-port memory request.
REQ-012 SHALL have ports mem_rdata_i, input, 32, and mem_ack_i, input, 1, meaning memory read data and the completion strobe.
REQ-013 SHALL have ports stall_if_o, output, 1, and stall_d_o, output, 1, meaning stall requests to the pipeline hazard logic.
REQ-014 SHALL have ports err_o, output, 1, meaning sticky timeout flag, and err_clr_i, input, 1, meaning clear err_o.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY_IF and BUSY_D.
REQ-016 In IDLE, SHALL grant d_req_i over if_req_i, unless run_cnt==MAX_RUN and both requests are high, in which case fetch SHALL be granted.
REQ-017 SHALL increment run_cnt on each data grant while if_req_i is high, and clear it on a fetch grant or on a data grant with if_req_i low.
REQ-018 On grant, SHALL latch the requester address, we and wdata into mem_addr_o, mem_we_o and mem_wdata_o (mem_we_o=0 for fetch), and raise mem_req_o the next cycle.
REQ-019 SHALL hold mem_req_o and the latched address, we and wdata stable until the cycle mem_ack_i is sampled high.
REQ-020 On mem_ack_i in BUSY_x, SHALL drop mem_req_o, return to IDLE, and pulse the matching *_valid_o for exactly one cycle in the next cycle.
REQ-021 On a read ack, SHALL register mem_rdata_i into the matching *_rdata_o; on a write ack, d_rdata_o SHALL hold its previous value.
REQ-022 Timing SHALL be: request in IDLE at cycle 0, mem_req_o high at cycles 1..k, ack at k, valid at k+1; back-to-back grants SHALL be possible from k+1.
REQ-023 stall_if_o SHALL equal if_req_i & ~if_valid_o, and stall_d_o SHALL equal d_req_i & ~d_valid_o (combinational).
REQ-024 If if_flush_i is high in IDLE, no fetch grant SHALL be made that cycle.
REQ-025 If if_flush_i is high in BUSY_IF or in the ack cycle, the access SHALL still complete at memory but the if_valid_o pulse and the if_rdata_o update SHALL be suppressed.
REQ-026 Requesters SHALL hold req, addr and wdata until their valid pulse; request deassertion before valid is unsupported except fetch via if_flush_i.
REQ-027 A 5-bit timer SHALL count cycles in BUSY_x; at TIMEOUT cycles without ack, mem_req_o SHALL drop, err_o SHALL set, the requester SHALL get a valid pulse with rdata 32'h0, and the FSM SHALL return to IDLE.
REQ-028 A mem_ack_i arriving in IDLE SHALL be ignored.
REQ-029 err_o SHALL stay set until err_clr_i; if a timeout and err_clr_i coincide, set SHALL win.

Reset
REQ-030 On rst_n low, the FSM SHALL go to IDLE immediately, asynchronously, including mid-access.
REQ-031 On reset, mem_req_o, mem_we_o, if_valid_o, d_valid_o and err_o SHALL be 0, and mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o, run_cnt and the timer SHALL be 0.
REQ-032 An access in flight at reset SHALL be abandoned with no valid pulse.

Verification
REQ-033 SHALL test a fetch alone: if_req_i at addr 0x010, ack 2 cycles after mem_req_o -> if_valid_o at cycle 4 with if_rdata_o = mem_rdata_i; stall_if_o high cycles 0-3.
REQ-034 SHALL test simultaneous requests: if_req_i and d_req_i (load 0x200) at cycle 0 -> data served first, fetch granted on the IDLE cycle after d_valid_o; stall_if_o high throughout.
REQ-035 SHALL test starvation: d_req_i held with 6 back-to-back stores and if_req_i held -> fetch granted after exactly 4 data grants.
REQ-036 SHALL test flush: if_flush_i pulsed during BUSY_IF -> memory ack completes, no if_valid_o, if_rdata_o unchanged.
REQ-037 SHALL test timeout: mem_ack_i never asserted -> mem_req_o drops after 15 cycles, d_valid_o pulses with d_rdata_o=0, err_o=1 until err_clr_i.
REQ-038 SHALL test mid-access reset: rst_n low in BUSY_D -> mem_req_o=0 at once, IDLE after release, no d_valid_o pulse.
